// File: rtl/axi_mmio_master_if.sv
// axi_mmio_master_if
//   Bundles the request/response command channels and the single-beat
//   AXI4 master channels (io_axi4_0_*) used by axi_mmio_master.
//   modport master : the bridge side (drives cmd_ready, rsp_*, AXI valids/payload)
//   modport slave  : the opposite side (command source, response sink, AXI slave)
interface axi_mmio_master_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [30:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic [2:0]  cmd_size;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  // AXI4 write address
  logic        io_axi4_0_aw_valid;
  logic        io_axi4_0_aw_ready;
  logic [3:0]  io_axi4_0_aw_id;
  logic [30:0] io_axi4_0_aw_addr;
  logic [7:0]  io_axi4_0_aw_len;
  logic [2:0]  io_axi4_0_aw_size;
  logic [1:0]  io_axi4_0_aw_burst;
  // AXI4 write data
  logic        io_axi4_0_w_valid;
  logic        io_axi4_0_w_ready;
  logic [63:0] io_axi4_0_w_data;
  logic [7:0]  io_axi4_0_w_strb;
  logic        io_axi4_0_w_last;
  // AXI4 write response
  logic        io_axi4_0_b_valid;
  logic        io_axi4_0_b_ready;
  logic [3:0]  io_axi4_0_b_id;
  logic [1:0]  io_axi4_0_b_resp;
  // AXI4 read address
  logic        io_axi4_0_ar_valid;
  logic        io_axi4_0_ar_ready;
  logic [3:0]  io_axi4_0_ar_id;
  logic [30:0] io_axi4_0_ar_addr;
  logic [7:0]  io_axi4_0_ar_len;
  logic [2:0]  io_axi4_0_ar_size;
  logic [1:0]  io_axi4_0_ar_burst;
  // AXI4 read data
  logic        io_axi4_0_r_valid;
  logic        io_axi4_0_r_ready;
  logic [3:0]  io_axi4_0_r_id;
  logic [63:0] io_axi4_0_r_data;
  logic [1:0]  io_axi4_0_r_resp;
  logic        io_axi4_0_r_last;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output io_axi4_0_aw_valid, io_axi4_0_aw_id, io_axi4_0_aw_addr, io_axi4_0_aw_len,
           io_axi4_0_aw_size, io_axi4_0_aw_burst,
    input  io_axi4_0_aw_ready,
    output io_axi4_0_w_valid, io_axi4_0_w_data, io_axi4_0_w_strb, io_axi4_0_w_last,
    input  io_axi4_0_w_ready,
    input  io_axi4_0_b_valid, io_axi4_0_b_id, io_axi4_0_b_resp,
    output io_axi4_0_b_ready,
    output io_axi4_0_ar_valid, io_axi4_0_ar_id, io_axi4_0_ar_addr, io_axi4_0_ar_len,
           io_axi4_0_ar_size, io_axi4_0_ar_burst,
    input  io_axi4_0_ar_ready,
    input  io_axi4_0_r_valid, io_axi4_0_r_id, io_axi4_0_r_data, io_axi4_0_r_resp,
           io_axi4_0_r_last,
    output io_axi4_0_r_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  io_axi4_0_aw_valid, io_axi4_0_aw_id, io_axi4_0_aw_addr, io_axi4_0_aw_len,
           io_axi4_0_aw_size, io_axi4_0_aw_burst,
    output io_axi4_0_aw_ready,
    input  io_axi4_0_w_valid, io_axi4_0_w_data, io_axi4_0_w_strb, io_axi4_0_w_last,
    output io_axi4_0_w_ready,
    output io_axi4_0_b_valid, io_axi4_0_b_id, io_axi4_0_b_resp,
    input  io_axi4_0_b_ready,
    input  io_axi4_0_ar_valid, io_axi4_0_ar_id, io_axi4_0_ar_addr, io_axi4_0_ar_len,
           io_axi4_0_ar_size, io_axi4_0_ar_burst,
    output io_axi4_0_ar_ready,
    output io_axi4_0_r_valid, io_axi4_0_r_id, io_axi4_0_r_data, io_axi4_0_r_resp,
           io_axi4_0_r_last,
    input  io_axi4_0_r_ready
  );
endinterface

// File: rtl/axi_mmio_master.sv
// axi_mmio_master
//   Turns one MMIO command at a time into a single-beat AXI4 read or write
//   and returns the result on a held response channel.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous active-high reset
//     bus    - axi_mmio_master_if.master: cmd_*, rsp_*, io_axi4_0_{aw,w,b,ar,r}_*
//   Parameters:
//     AXI_ID      - id driven on AW/AR and expected back on B/R
//     ALIGN_CHECK - reject misaligned / oversized requests locally (resp 2'b11)
module axi_mmio_master #(
  parameter logic [3:0] AXI_ID      = 4'h0,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  axi_mmio_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_e;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_ALIGN  = 2'b11;

  state_e      state_q, state_d;
  logic        aw_valid_q, aw_valid_d;
  logic        w_valid_q, w_valid_d;
  logic        ar_valid_q, ar_valid_d;
  logic        b_ready_q, b_ready_d;
  logic        r_ready_q, r_ready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [30:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [2:0]  size_q, size_d;

  logic misaligned, bad_align;
  logic aw_fire, w_fire, aw_done_now, w_done_now;

  // Natural alignment of the access; sizes above 8 bytes never fit the 64-bit bus.
  always_comb begin
    bad_align = 1'b0;
    case (bus.cmd_size)
      3'd0:    bad_align = 1'b0;
      3'd1:    bad_align = bus.cmd_addr[0];
      3'd2:    bad_align = |bus.cmd_addr[1:0];
      3'd3:    bad_align = |bus.cmd_addr[2:0];
      default: bad_align = 1'b1;
    endcase
    misaligned = ALIGN_CHECK && bad_align;
  end

  assign aw_fire     = aw_valid_q && bus.io_axi4_0_aw_ready;
  assign w_fire      = w_valid_q && bus.io_axi4_0_w_ready;
  assign aw_done_now = aw_done_q || aw_fire;
  assign w_done_now  = w_done_q || w_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= 64'd0;
      addr_q      <= 31'd0;
      wdata_q     <= 64'd0;
      wstrb_q     <= 8'd0;
      size_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      ar_valid_q  <= ar_valid_d;
      b_ready_q   <= b_ready_d;
      r_ready_q   <= r_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    ar_valid_d  = ar_valid_q;
    b_ready_d   = b_ready_q;
    r_ready_d   = r_ready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          wstrb_d     = bus.cmd_wstrb;
          size_d      = bus.cmd_size;
          rsp_write_d = bus.cmd_write;
          rsp_rdata_d = 64'd0;  // stale read data must not leak into the next response
          if (misaligned) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = RESP_ALIGN;
          end else if (bus.cmd_write) begin
            state_d    = WR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = RA;
            ar_valid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently; either order or the same cycle.
        if (aw_fire) aw_valid_d = 1'b0;
        if (w_fire)  w_valid_d  = 1'b0;
        aw_done_d = aw_done_now;
        w_done_d  = w_done_now;
        if (aw_done_now && w_done_now) begin
          state_d   = WB;
          b_ready_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WB: begin
        if (b_ready_q && bus.io_axi4_0_b_valid) begin
          state_d     = RSP;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = (bus.io_axi4_0_b_id != AXI_ID) ? RESP_SLVERR : bus.io_axi4_0_b_resp;
        end
      end
      RA: begin
        if (bus.io_axi4_0_ar_ready) begin
          state_d    = RD;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RD: begin
        if (r_ready_q && bus.io_axi4_0_r_valid) begin
          state_d     = RSP;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.io_axi4_0_r_data;
          rsp_resp_d  = ((bus.io_axi4_0_r_id != AXI_ID) || !bus.io_axi4_0_r_last)
                        ? RESP_SLVERR : bus.io_axi4_0_r_resp;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;

  assign bus.io_axi4_0_aw_valid = aw_valid_q;
  assign bus.io_axi4_0_aw_id    = AXI_ID;
  assign bus.io_axi4_0_aw_addr  = addr_q;
  assign bus.io_axi4_0_aw_len   = 8'd0;
  assign bus.io_axi4_0_aw_size  = size_q;
  assign bus.io_axi4_0_aw_burst = 2'b01;

  assign bus.io_axi4_0_w_valid  = w_valid_q;
  assign bus.io_axi4_0_w_data   = wdata_q;
  assign bus.io_axi4_0_w_strb   = wstrb_q;
  assign bus.io_axi4_0_w_last   = 1'b1;

  assign bus.io_axi4_0_b_ready  = b_ready_q;

  assign bus.io_axi4_0_ar_valid = ar_valid_q;
  assign bus.io_axi4_0_ar_id    = AXI_ID;
  assign bus.io_axi4_0_ar_addr  = addr_q;
  assign bus.io_axi4_0_ar_len   = 8'd0;
  assign bus.io_axi4_0_ar_size  = size_q;
  assign bus.io_axi4_0_ar_burst = 2'b01;

  assign bus.io_axi4_0_r_ready  = r_ready_q;

endmodule

// File: tb/tb_axi_mmio_master.sv
// tb_axi_mmio_master
//   Directed bench for axi_mmio_master: the initial block plays command source,
//   response sink and AXI slave, stepping one clock at a time and sampling
//   1ns after each rising edge.
module tb_axi_mmio_master;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  axi_mmio_master_if bus ();

  axi_mmio_master #(.AXI_ID(4'h0), .ALIGN_CHECK(1'b1)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [30:0] addr, input logic [63:0] data,
                       input logic [7:0] strb, input logic [2:0] size);
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
    bus.cmd_size  = size;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // rsp must be held with cmd_ready low until acknowledged; ready returns next cycle
  task automatic ack();
    chk("cmd_ready_in_rsp", bus.cmd_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", bus.rsp_valid, 1'b0);
    chk("cmd_ready_after_ack", bus.cmd_ready, 1'b1);
  endtask

  task automatic wait_rsp(input string tag);
    int cyc = 0;
    while (!bus.rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk(tag, bus.rsp_valid, 1'b1);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [63:0] data,
                        input logic [1:0] resp, input logic last);
    bus.io_axi4_0_r_valid = 1'b1;
    bus.io_axi4_0_r_id    = id;
    bus.io_axi4_0_r_data  = data;
    bus.io_axi4_0_r_resp  = resp;
    bus.io_axi4_0_r_last  = last;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.cmd_wstrb = 0; bus.cmd_size = 0; bus.rsp_ready = 0;
    bus.io_axi4_0_aw_ready = 0; bus.io_axi4_0_w_ready = 0;
    bus.io_axi4_0_b_valid = 0; bus.io_axi4_0_b_id = 0; bus.io_axi4_0_b_resp = 0;
    bus.io_axi4_0_ar_ready = 0;
    bus.io_axi4_0_r_valid = 0; bus.io_axi4_0_r_id = 0; bus.io_axi4_0_r_data = 0;
    bus.io_axi4_0_r_resp = 0; bus.io_axi4_0_r_last = 0;
    step(); step();

    // reset state
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_aw_valid", bus.io_axi4_0_aw_valid, 1'b0);
    chk("rst_w_valid", bus.io_axi4_0_w_valid, 1'b0);
    chk("rst_ar_valid", bus.io_axi4_0_ar_valid, 1'b0);
    chk("rst_b_ready", bus.io_axi4_0_b_ready, 1'b0);
    chk("rst_r_ready", bus.io_axi4_0_r_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_resp", bus.rsp_resp, 2'b00);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    rst = 1'b0;

    // write, AW and W ready together -> minimum latency
    bus.io_axi4_0_aw_ready = 1; bus.io_axi4_0_w_ready = 1;
    issue(1'b1, 31'h60000004, 64'h11223344, 8'h0F, 3'd2);
    chk("w1_cmd_ready", bus.cmd_ready, 1'b0);
    chk("w1_aw_valid", bus.io_axi4_0_aw_valid, 1'b1);
    chk("w1_w_valid", bus.io_axi4_0_w_valid, 1'b1);
    chk("w1_aw_addr", bus.io_axi4_0_aw_addr, 31'h60000004);
    chk("w1_aw_size", bus.io_axi4_0_aw_size, 3'd2);
    chk("w1_aw_len", bus.io_axi4_0_aw_len, 8'd0);
    chk("w1_aw_burst", bus.io_axi4_0_aw_burst, 2'b01);
    chk("w1_aw_id", bus.io_axi4_0_aw_id, 4'h0);
    chk("w1_w_data", bus.io_axi4_0_w_data, 64'h11223344);
    chk("w1_w_strb", bus.io_axi4_0_w_strb, 8'h0F);
    chk("w1_w_last", bus.io_axi4_0_w_last, 1'b1);
    step();
    chk("w1_aw_drop", bus.io_axi4_0_aw_valid, 1'b0);
    chk("w1_w_drop", bus.io_axi4_0_w_valid, 1'b0);
    chk("w1_b_ready", bus.io_axi4_0_b_ready, 1'b1);
    bus.io_axi4_0_aw_ready = 0; bus.io_axi4_0_w_ready = 0;
    bus.io_axi4_0_b_valid = 1; bus.io_axi4_0_b_resp = 2'b00; bus.io_axi4_0_b_id = 4'h0;
    step();
    bus.io_axi4_0_b_valid = 0;
    chk("w1_rsp_valid_lat3", bus.rsp_valid, 1'b1);
    chk("w1_rsp_write", bus.rsp_write, 1'b1);
    chk("w1_rsp_resp", bus.rsp_resp, 2'b00);
    chk("w1_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("w1_b_ready_drop", bus.io_axi4_0_b_ready, 1'b0);
    ack();

    // read with AR ready held off for 5 cycles
    issue(1'b0, 31'h60010008, 64'd0, 8'd0, 3'd3);
    for (int i = 0; i < 5; i++) begin
      chk("r1_ar_valid_hold", bus.io_axi4_0_ar_valid, 1'b1);
      chk("r1_ar_addr_hold", bus.io_axi4_0_ar_addr, 31'h60010008);
      chk("r1_ar_size_hold", bus.io_axi4_0_ar_size, 3'd3);
      chk("r1_r_ready_early", bus.io_axi4_0_r_ready, 1'b0);
      step();
    end
    bus.io_axi4_0_ar_ready = 1;
    step();
    bus.io_axi4_0_ar_ready = 0;
    chk("r1_ar_drop", bus.io_axi4_0_ar_valid, 1'b0);
    chk("r1_r_ready", bus.io_axi4_0_r_ready, 1'b1);
    r_beat(4'h0, 64'hDEADBEEFCAFEF00D, 2'b00, 1'b1);
    step();
    bus.io_axi4_0_r_valid = 0;
    chk("r1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("r1_rsp_write", bus.rsp_write, 1'b0);
    chk("r1_rsp_rdata", bus.rsp_rdata, 64'hDEADBEEFCAFEF00D);
    chk("r1_rsp_resp", bus.rsp_resp, 2'b00);
    chk("r1_r_ready_drop", bus.io_axi4_0_r_ready, 1'b0);
    ack();

    // write: W accepted at once, AW delayed 3 cycles, then one B with EXOKAY
    bus.io_axi4_0_w_ready = 1;
    issue(1'b1, 31'h60000010, 64'hA5A5A5A55A5A5A5A, 8'hFF, 3'd3);
    chk("w2_aw_valid", bus.io_axi4_0_aw_valid, 1'b1);
    chk("w2_w_valid", bus.io_axi4_0_w_valid, 1'b1);
    step();
    bus.io_axi4_0_w_ready = 0;
    for (int i = 0; i < 2; i++) begin
      chk("w2_w_dropped", bus.io_axi4_0_w_valid, 1'b0);
      chk("w2_aw_held", bus.io_axi4_0_aw_valid, 1'b1);
      chk("w2_b_ready_early", bus.io_axi4_0_b_ready, 1'b0);
      step();
    end
    chk("w2_aw_held_last", bus.io_axi4_0_aw_valid, 1'b1);
    bus.io_axi4_0_aw_ready = 1;
    step();
    bus.io_axi4_0_aw_ready = 0;
    chk("w2_aw_drop", bus.io_axi4_0_aw_valid, 1'b0);
    chk("w2_w_still_low", bus.io_axi4_0_w_valid, 1'b0);
    step();
    chk("w2_b_ready_wait", bus.io_axi4_0_b_ready, 1'b1);
    chk("w2_no_rsp_yet", bus.rsp_valid, 1'b0);
    bus.io_axi4_0_b_valid = 1; bus.io_axi4_0_b_resp = 2'b01;
    step();
    bus.io_axi4_0_b_valid = 0; bus.io_axi4_0_b_resp = 2'b00;
    chk("w2_rsp_valid", bus.rsp_valid, 1'b1);
    chk("w2_rsp_resp", bus.rsp_resp, 2'b01);
    chk("w2_one_b_only", bus.io_axi4_0_b_ready, 1'b0);
    ack();

    // misaligned read: rejected locally, no AXI traffic, rdata cleared
    issue(1'b0, 31'h60000003, 64'd0, 8'd0, 3'd2);
    chk("ma_ar_valid", bus.io_axi4_0_ar_valid, 1'b0);
    chk("ma_rsp_valid", bus.rsp_valid, 1'b1);
    chk("ma_rsp_resp", bus.rsp_resp, 2'b11);
    chk("ma_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("ma_rsp_write", bus.rsp_write, 1'b0);
    ack();
    chk("ma_ar_valid_after", bus.io_axi4_0_ar_valid, 1'b0);

    // oversize write (size 4) on an aligned address is also rejected
    issue(1'b1, 31'h60000000, 64'h1, 8'hFF, 3'd4);
    chk("os_aw_valid", bus.io_axi4_0_aw_valid, 1'b0);
    chk("os_rsp_resp", bus.rsp_resp, 2'b11);
    chk("os_rsp_write", bus.rsp_write, 1'b1);
    ack();

    // read answered with wrong r_id -> SLVERR
    bus.io_axi4_0_ar_ready = 1;
    issue(1'b0, 31'h60000020, 64'd0, 8'd0, 3'd3);
    step();
    r_beat(4'h5, 64'h0123456789ABCDEF, 2'b00, 1'b1);
    step();
    bus.io_axi4_0_r_valid = 0;
    chk("rid_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rid_rsp_resp", bus.rsp_resp, 2'b10);
    ack();

    // read answered with r_last=0 -> SLVERR
    issue(1'b0, 31'h60000028, 64'd0, 8'd0, 3'd3);
    step();
    r_beat(4'h0, 64'h0123456789ABCDEF, 2'b00, 1'b0);
    step();
    bus.io_axi4_0_r_valid = 0;
    chk("rlast_rsp_resp", bus.rsp_resp, 2'b10);
    ack();
    bus.io_axi4_0_ar_ready = 0;

    // write answered with wrong b_id -> SLVERR
    bus.io_axi4_0_aw_ready = 1; bus.io_axi4_0_w_ready = 1;
    issue(1'b1, 31'h60000030, 64'h5, 8'h01, 3'd0);
    step();
    bus.io_axi4_0_b_valid = 1; bus.io_axi4_0_b_id = 4'h3;
    step();
    bus.io_axi4_0_b_valid = 0; bus.io_axi4_0_b_id = 4'h0;
    chk("bid_rsp_resp", bus.rsp_resp, 2'b10);
    ack();

    // reset while waiting for B: transaction abandoned, new command taken at once
    issue(1'b1, 31'h60000040, 64'h77, 8'hFF, 3'd3);
    step();
    bus.io_axi4_0_aw_ready = 0; bus.io_axi4_0_w_ready = 0;
    chk("rwb_in_wb", bus.io_axi4_0_b_ready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rwb_aw_valid", bus.io_axi4_0_aw_valid, 1'b0);
    chk("rwb_w_valid", bus.io_axi4_0_w_valid, 1'b0);
    chk("rwb_ar_valid", bus.io_axi4_0_ar_valid, 1'b0);
    chk("rwb_b_ready", bus.io_axi4_0_b_ready, 1'b0);
    chk("rwb_rsp_valid", bus.rsp_valid, 1'b0);
    bus.io_axi4_0_ar_ready = 1;
    issue(1'b0, 31'h60000048, 64'd0, 8'd0, 3'd3);
    chk("rwb_new_ar_valid", bus.io_axi4_0_ar_valid, 1'b1);
    chk("rwb_no_rsp", bus.rsp_valid, 1'b0);
    step();
    bus.io_axi4_0_ar_ready = 0;
    r_beat(4'h0, 64'hFEEDFACE00000001, 2'b00, 1'b1);
    wait_rsp("rwb_rsp_seen");
    bus.io_axi4_0_r_valid = 0;
    chk("rwb_rsp_write", bus.rsp_write, 1'b0);
    chk("rwb_rsp_rdata", bus.rsp_rdata, 64'hFEEDFACE00000001);
    chk("rwb_rsp_resp", bus.rsp_resp, 2'b00);
    ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
